// File: rtl/multicycle_control_unit.sv
// Main control FSM and ALU decoder for a multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Moore control word is registered alongside the state; pc_write, imm_src and alu_control use live inputs.
module multicycle_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [3:0]       alu_control,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  state_t           state_reg;
  state_t           state_next;
  ctrl_t            ctrl_reg;
  logic [CNT_W-1:0] instret_reg;
  logic             alu_f3_ok;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = AOP_FN;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = AOP_FN;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = 2'b10;
        c.alu_op     = AOP_SUB;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = alu_f3_ok ? S_EXECR : S_ILLEGAL;
          OP_I:         state_next = alu_f3_ok ? S_EXECI : S_ILLEGAL;
          OP_BEQ:       state_next = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_ILLEGAL:  state_next = S_ILLEGAL;
      default:    state_next = S_FETCH;
    endcase
  end

  // The control word is computed from the next state so it lines up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      ctrl_reg    <= decode_ctrl(S_FETCH);
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= decode_ctrl(state_next);
      if (ctrl_reg.instr_done) begin
        instret_reg <= instret_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // The control word resets to FETCH values, so enables are masked while reset is held.
  assign pc_write   = rst_n & (ctrl_reg.pc_update | (ctrl_reg.branch & zero));
  assign mem_write  = rst_n & ctrl_reg.mem_write;
  assign ir_write   = rst_n & ctrl_reg.ir_write;
  assign reg_write  = rst_n & ctrl_reg.reg_write;
  assign adr_src    = ctrl_reg.adr_src;
  assign result_src = ctrl_reg.result_src;
  assign alu_src_a  = ctrl_reg.alu_src_a;
  assign alu_src_b  = ctrl_reg.alu_src_b;
  assign instr_done = ctrl_reg.instr_done;
  assign illegal    = ctrl_reg.illegal;
  assign instret    = instret_reg;

  always_comb begin
    imm_src = 2'b00;
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (ctrl_reg.alu_op)
      AOP_ADD: alu_control = ALU_ADD;
      AOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_control = ((opcode == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: stimulus pushes a per-instruction expected summary, a monitor
// accumulates what the DUT does over the instruction and compares at instr_done.
module tb_multicycle_control_unit;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          funct7b5 = 1'b0;
  logic          zero = 1'b0;
  logic          pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]    result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0]    alu_control;
  logic          instr_done, illegal;
  logic [CW-1:0] instret;

  multicycle_control_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .instr_done(instr_done),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5;

  typedef struct {
    int         kind;
    int         lat;
    int         n_ir, n_pc, n_reg, n_mem, n_adr;
    logic [3:0] alu3;
    logic [1:0] srca3, srcb3, imm2, last_res;
    logic       last_reg;
    int         ret_before;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   model_ret = 0;
  int   txn = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", nm, act, expv);
    end
  endtask

  function automatic logic [6:0] op_of(input int k);
    case (k)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BEQ:   return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  // Reference: what each instruction class must do over its whole lifetime.
  function automatic exp_t model(input int k, input logic [2:0] f3, input logic b5,
                                 input logic z, input int ret);
    exp_t e;
    e.kind = k; e.n_ir = 1; e.n_pc = 1; e.n_reg = 0; e.n_mem = 0; e.n_adr = 0;
    e.alu3 = 4'b0010; e.srca3 = 2'b10; e.srcb3 = 2'b01; e.imm2 = 2'b00;
    e.last_res = 2'b00; e.last_reg = 1'b0; e.ret_before = ret;
    case (k)
      K_LW: begin e.lat = 5; e.n_reg = 1; e.n_adr = 1; e.last_res = 2'b01; e.last_reg = 1; end
      K_SW: begin e.lat = 4; e.n_mem = 1; e.n_adr = 1; e.imm2 = 2'b01; end
      K_R, K_I: begin
        e.lat = 4; e.n_reg = 1; e.last_reg = 1;
        if (k == K_R) e.srcb3 = 2'b00;
        case (f3)
          3'b000:  e.alu3 = (k == K_R && b5) ? 4'b0110 : 4'b0010;
          3'b010:  e.alu3 = 4'b0111;
          3'b110:  e.alu3 = 4'b0001;
          default: e.alu3 = 4'b0000;
        endcase
      end
      K_BEQ: begin
        e.lat = 3; e.alu3 = 4'b0110; e.srcb3 = 2'b00; e.imm2 = 2'b10;
        e.n_pc = z ? 2 : 1;
      end
      default: begin
        e.lat = 4; e.n_reg = 1; e.last_reg = 1; e.n_pc = 2;
        e.srca3 = 2'b01; e.srcb3 = 2'b10; e.imm2 = 2'b11;
      end
    endcase
    return e;
  endfunction

  // Called at the start of a FETCH cycle (just after a rising edge).
  task automatic issue(input int k, input logic [2:0] f3, input logic b5, input logic z);
    exp_t e;
    opcode = op_of(k); funct3 = f3; funct7b5 = b5; zero = z;
    e = model(k, f3, b5, z, model_ret);
    q.push_back(e);
    repeat (e.lat) @(posedge clk);
    #1;
    model_ret = (model_ret + 1) % (1 << CW);
  endtask

  // Monitor
  initial begin
    int c, n_ir, n_pc, n_reg, n_mem, n_adr;
    logic [3:0] a3;
    logic [1:0] sa3, sb3, im2;
    exp_t e;
    c = 0; n_ir = 0; n_pc = 0; n_reg = 0; n_mem = 0; n_adr = 0;
    a3 = 0; sa3 = 0; sb3 = 0; im2 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("enables_in_reset", {28'd0, pc_write, mem_write, ir_write, reg_write}, 32'd0);
        c = 0; n_ir = 0; n_pc = 0; n_reg = 0; n_mem = 0; n_adr = 0;
      end else begin
        c++;
        n_ir += int'(ir_write); n_pc += int'(pc_write); n_reg += int'(reg_write);
        n_mem += int'(mem_write); n_adr += int'(adr_src);
        if (c == 2) im2 = imm_src;
        if (c == 3) begin a3 = alu_control; sa3 = alu_src_a; sb3 = alu_src_b; end
        if (instr_done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            txn++;
            $display("txn %0d kind=%0d cycles=%0d alu=%b instret=%0d", txn, e.kind, c, a3, instret);
            chk("latency", c, e.lat);
            chk("ir_write_cnt", n_ir, e.n_ir);
            chk("pc_write_cnt", n_pc, e.n_pc);
            chk("reg_write_cnt", n_reg, e.n_reg);
            chk("mem_write_cnt", n_mem, e.n_mem);
            chk("adr_src_cnt", n_adr, e.n_adr);
            chk("alu_control_c3", a3, e.alu3);
            chk("alu_src_a_c3", sa3, e.srca3);
            chk("alu_src_b_c3", sb3, e.srcb3);
            chk("imm_src_c2", im2, e.imm2);
            chk("result_src_last", result_src, e.last_res);
            chk("reg_write_last", reg_write, e.last_reg);
            chk("illegal_flag", illegal, 0);
            chk("instret", instret, e.ret_before);
          end
          c = 0; n_ir = 0; n_pc = 0; n_reg = 0; n_mem = 0; n_adr = 0;
        end
      end
    end
  end

  task automatic reset_pulse(input int cycles);
    @(posedge clk); #1;
    rst_n = 0;
    q.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1;
    model_ret = 0;
    chk("instret_after_reset", instret, 0);
    chk("illegal_after_reset", illegal, 0);
  endtask

  task automatic illegal_case(input logic [6:0] op, input logic [2:0] f3);
    opcode = op; funct3 = f3; funct7b5 = 0; zero = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("illegal_set", illegal, 1);
      chk("illegal_enables", {27'd0, pc_write, mem_write, ir_write, reg_write, instr_done}, 0);
    end
    reset_pulse(1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    chk("instret_reset", instret, 0);
    // addi, then sub/or/and/slt, lw, sw, beq taken/not, jal
    issue(K_I, 3'b000, 1'b0, 1'b0);
    issue(K_R, 3'b000, 1'b1, 1'b0);
    issue(K_R, 3'b110, 1'b0, 1'b0);
    issue(K_R, 3'b111, 1'b0, 1'b0);
    issue(K_R, 3'b010, 1'b0, 1'b0);
    issue(K_LW, 3'b010, 1'b0, 1'b0);
    issue(K_SW, 3'b010, 1'b0, 1'b1);
    issue(K_BEQ, 3'b000, 1'b0, 1'b1);
    issue(K_BEQ, 3'b000, 1'b0, 1'b0);
    issue(K_JAL, 3'b101, 1'b1, 1'b1);
    // Reset two cycles into an R-type (now in EXECR), held for 2 cycles
    opcode = op_of(K_R); funct3 = 3'b000; funct7b5 = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_ret = 0;
    chk("instret_mid_reset", instret, 0);
    issue(K_I, 3'b111, 1'b1, 1'b0);
    for (int n = 0; n < 60; n++) begin
      int k;
      logic [2:0] f3;
      k = $urandom_range(0, 5);
      case ($urandom_range(0, 3))
        0: f3 = 3'b000;
        1: f3 = 3'b010;
        2: f3 = 3'b110;
        default: f3 = 3'b111;
      endcase
      if (k == K_BEQ) f3 = 3'b000;
      issue(k, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    @(posedge clk); #1;
    illegal_case(7'h7F, 3'b000);
    illegal_case(op_of(K_R), 3'b001);
    illegal_case(op_of(K_BEQ), 3'b001);
    issue(K_SW, 3'b010, 1'b0, 1'b0);
    @(negedge clk);
    chk("queue_drained_end", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
